// File: rtl/fc_mp_pkg.sv
// fc_mp_pkg: shared types and helpers for the time-multiplexed FC layer.
//   state_e      - controller state encoding (also visible on dbg_state)
//   acc_bits     - accumulator width that cannot overflow for N inputs
//   sat_clamp    - clamp a wide signed value into a signed 'bits' range
//   sext_weight  - take the low w_bits of a weight container, sign-extended
package fc_mp_pkg;

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_IDLE = 3'd1,
        ST_ACC  = 3'd2,
        ST_POST = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    localparam int WideBits = 64;

    // One extra bit on top of product width + log2(N) covers the bias term.
    function automatic int acc_bits(input int bit_size, input int w_bits, input int n_inputs);
        return bit_size + w_bits + $clog2(n_inputs) + 1;
    endfunction

    function automatic logic signed [WideBits-1:0] sat_clamp(
        input logic signed [WideBits-1:0] v,
        input int                         bits
    );
        logic signed [WideBits-1:0] hi;
        logic signed [WideBits-1:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Left shift drops the unused container bits, arithmetic right shift
    // brings the used field back down with its sign replicated.
    function automatic logic signed [15:0] sext_weight(input logic [15:0] raw, input int w_bits);
        logic signed [15:0] t;
        t = signed'(raw << (16 - w_bits));
        return t >>> (16 - w_bits);
    endfunction

endpackage

// File: rtl/fc_layer_mp_mac_col.sv
// fc_mac_col: one nerve's MAC column.
//   data/weights : NumOfInputs activations and their (used-width) weights
//   bias         : per-nerve bias, used when load_bias is high
//   clr          : clear accumulator (highest priority)
//   load_bias    : acc = sext(bias) + beat products (first beat of a vector)
//   acc_en       : acc = acc + beat products
//   acc          : registered accumulator value
module fc_mac_col
    import fc_mp_pkg::*;
#(
    parameter int BitSize        = 8,
    parameter int Weight_BitSize = 2,
    parameter int NumOfInputs    = 2,
    parameter int AccBits        = 13
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic                                clr,
    input  logic                                load_bias,
    input  logic                                acc_en,
    input  logic [BitSize-1:0]                  bias,
    input  logic [NumOfInputs*BitSize-1:0]      data,
    input  logic [NumOfInputs*Weight_BitSize-1:0] weights,
    output logic [AccBits-1:0]                  acc
);

    logic signed [AccBits-1:0] acc_q;
    logic signed [AccBits-1:0] acc_d;
    logic signed [AccBits-1:0] beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < NumOfInputs; i++) begin
            beat_sum = beat_sum
                + AccBits'(signed'(data[i*BitSize +: BitSize]))
                * AccBits'(sext_weight(16'(weights[i*Weight_BitSize +: Weight_BitSize]),
                                       Weight_BitSize));
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (load_bias) begin
            acc_d = AccBits'(signed'(bias)) + beat_sum;
        end else if (acc_en) begin
            acc_d = acc_q + beat_sum;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fc_layer_mp.sv
// fc_layer_mp: fully-connected layer with a time-multiplexed MAC array.
//   Weight load : en_l_b + in_weights, one row (input k, all nerves) per cycle
//   Input       : in_valid/in_ready beats of NumOfInputs activations, in_start
//                 marks beat 0, in_partial_sum is the bias sampled on beat 0
//   Output      : out_valid/out_ready chunks of NumOfNerves/DepthOut results,
//                 out_start on chunk 0, out_done on the final chunk
//   Status      : out_err (one-cycle framing error pulse), weights_loaded,
//                 dbg_state (current controller state)
// Handshake: a beat/chunk transfers on a rising clk edge where valid and
// ready are both high; a source holds its payload stable while valid is high
// and ready is low.
module fc_layer_mp
    import fc_mp_pkg::*;
#(
    parameter int BitSize        = 8,
    parameter int Weight_BitSize = 2,
    parameter int M_W_BitSize    = 4,
    parameter int NumOfInputs    = 2,
    parameter int DepthIn        = 2,
    parameter int NumOfNerves    = 4,
    parameter int DepthOut       = 2,
    parameter int Relu_En        = 1,
    parameter int Shift          = 0
) (
    input  logic                                        clk,
    input  logic                                        res_n,
    input  logic                                        en_l_b,
    input  logic [NumOfNerves*M_W_BitSize-1:0]          in_weights,
    input  logic                                        in_start,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [NumOfInputs*BitSize-1:0]              in_data,
    input  logic [NumOfNerves*BitSize-1:0]              in_partial_sum,
    input  logic                                        out_ready,
    output logic                                        out_valid,
    output logic                                        out_start,
    output logic                                        out_done,
    output logic [(NumOfNerves/DepthOut)*BitSize-1:0]   out_data,
    output logic                                        out_err,
    output logic                                        weights_loaded,
    output logic [2:0]                                  dbg_state
);

    localparam int N       = NumOfInputs * DepthIn;
    localparam int AccBits = acc_bits(BitSize, Weight_BitSize, N);
    localparam int ChunkW  = NumOfNerves / DepthOut;
    localparam int RowW    = (N > 1) ? $clog2(N) : 1;
    localparam int BcntW   = (DepthIn > 1) ? $clog2(DepthIn) : 1;
    localparam int OcntW   = (DepthOut > 1) ? $clog2(DepthOut) : 1;
    localparam int NerveW  = (NumOfNerves > 1) ? $clog2(NumOfNerves) : 1;

    if (NumOfNerves % DepthOut != 0) begin : g_bad_depth_out
        $error("fc_layer_mp: NumOfNerves must be a multiple of DepthOut");
    end

    state_e                    state_q, state_d;
    logic [RowW-1:0]           wcnt_q, wcnt_d;
    logic [BcntW-1:0]          bcnt_q, bcnt_d;
    logic [OcntW-1:0]          ocnt_q, ocnt_d;
    logic                      wl_q, wl_d;
    logic                      err_q, err_d;
    logic [Weight_BitSize-1:0] w_q [N][NumOfNerves];
    logic [Weight_BitSize-1:0] w_d [N][NumOfNerves];
    logic [BitSize-1:0]        res_q [NumOfNerves];
    logic [BitSize-1:0]        res_d [NumOfNerves];

    logic [AccBits-1:0]         acc [NumOfNerves];
    logic signed [WideBits-1:0] post_wide [NumOfNerves];
    logic [BitSize-1:0]         post_res [NumOfNerves];
    logic                       in_fire, do_load, mac_load, mac_acc, mac_clr;
    logic [BcntW-1:0]           beat_idx;
    logic                       unused_w_bits;

    // Upper container bits of each weight are deliberately ignored.
    assign unused_w_bits = ^in_weights;

    // A weight-load cycle in IDLE blocks input so rows and beats never mix.
    assign in_ready = ((state_q == ST_IDLE) && !en_l_b) || (state_q == ST_ACC);
    assign in_fire  = in_valid && in_ready;
    assign do_load  = en_l_b && ((state_q == ST_LOAD) || (state_q == ST_IDLE));
    assign mac_clr  = (state_q == ST_POST);
    // A restart beat always uses weight rows of beat 0.
    assign beat_idx = mac_load ? '0 : bcnt_q;

    always_comb begin
        for (int j = 0; j < NumOfNerves; j++) begin
            post_wide[j] = WideBits'(signed'(acc[j]) >>> Shift);
            if ((Relu_En != 0) && (post_wide[j] < 0)) begin
                post_wide[j] = '0;
            end
            post_wide[j] = sat_clamp(post_wide[j], BitSize);
            post_res[j]  = post_wide[j][BitSize-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        ocnt_d   = ocnt_q;
        wl_d     = wl_q;
        err_d    = 1'b0;
        w_d      = w_q;
        res_d    = res_q;
        mac_load = 1'b0;
        mac_acc  = 1'b0;

        if (do_load) begin
            for (int j = 0; j < NumOfNerves; j++) begin
                w_d[wcnt_q][j] = in_weights[j*M_W_BitSize +: Weight_BitSize];
            end
            if (wcnt_q == RowW'(N - 1)) begin
                wcnt_d  = '0;
                wl_d    = 1'b1;
                state_d = ST_IDLE;
            end else begin
                wcnt_d  = wcnt_q + 1'b1;
                wl_d    = 1'b0;
                state_d = ST_LOAD;
            end
        end

        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (in_fire) begin
                    if (in_start) begin
                        mac_load = 1'b1;
                        err_d    = (state_q == ST_ACC);
                        if (DepthIn == 1) begin
                            bcnt_d  = '0;
                            state_d = ST_POST;
                        end else begin
                            bcnt_d  = BcntW'(1);
                            state_d = ST_ACC;
                        end
                    end else if (state_q == ST_IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        mac_acc = 1'b1;
                        if (bcnt_q == BcntW'(DepthIn - 1)) begin
                            bcnt_d  = '0;
                            state_d = ST_POST;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_POST: begin
                res_d   = post_res;
                ocnt_d  = '0;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (ocnt_q == OcntW'(DepthOut - 1)) begin
                        ocnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD: ;
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_LOAD;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            ocnt_q  <= '0;
            wl_q    <= 1'b0;
            err_q   <= 1'b0;
            w_q     <= '{default: '0};
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            ocnt_q  <= ocnt_d;
            wl_q    <= wl_d;
            err_q   <= err_d;
            w_q     <= w_d;
            res_q   <= res_d;
        end
    end

    for (genvar j = 0; j < NumOfNerves; j++) begin : g_col
        logic [NumOfInputs*Weight_BitSize-1:0] col_w;

        always_comb begin
            for (int i = 0; i < NumOfInputs; i++) begin
                col_w[i*Weight_BitSize +: Weight_BitSize] =
                    w_q[RowW'(int'(beat_idx) * NumOfInputs + i)][j];
            end
        end

        fc_mac_col #(
            .BitSize       (BitSize),
            .Weight_BitSize(Weight_BitSize),
            .NumOfInputs   (NumOfInputs),
            .AccBits       (AccBits)
        ) u_col (
            .clk      (clk),
            .res_n    (res_n),
            .clr      (mac_clr),
            .load_bias(mac_load),
            .acc_en   (mac_acc),
            .bias     (in_partial_sum[j*BitSize +: BitSize]),
            .data     (in_data),
            .weights  (col_w),
            .acc      (acc[j])
        );
    end

    assign out_valid      = (state_q == ST_OUT);
    assign out_start      = out_valid && (ocnt_q == '0);
    assign out_done       = out_valid && (ocnt_q == OcntW'(DepthOut - 1));
    assign out_err        = err_q;
    assign weights_loaded = wl_q;
    assign dbg_state      = state_q;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int k = 0; k < ChunkW; k++) begin
                out_data[k*BitSize +: BitSize] = res_q[NerveW'(int'(ocnt_q) * ChunkW + k)];
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_mp.sv
// tb_fc_layer_mp: directed + random bench for fc_layer_mp (default parameters).
// Two instances share all inputs: u_dut with ReLU, u_dut_nr without ReLU.
module tb_fc_layer_mp;

    logic        clk;
    logic        res_n;
    logic        en_l_b;
    logic [15:0] in_weights;
    logic        in_start;
    logic        in_valid;
    logic [15:0] in_data;
    logic [31:0] in_partial_sum;
    logic        out_ready;

    logic        in_ready, out_valid, out_start, out_done, out_err, weights_loaded;
    logic [15:0] out_data;
    logic [2:0]  dbg_state;
    logic        in_ready_nr, out_valid_nr, out_start_nr, out_done_nr, out_err_nr, wl_nr;
    logic [15:0] out_data_nr;
    logic [2:0]  dbg_state_nr;

    fc_layer_mp u_dut (
        .clk(clk), .res_n(res_n), .en_l_b(en_l_b), .in_weights(in_weights),
        .in_start(in_start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_partial_sum(in_partial_sum), .out_ready(out_ready),
        .out_valid(out_valid), .out_start(out_start), .out_done(out_done),
        .out_data(out_data), .out_err(out_err), .weights_loaded(weights_loaded),
        .dbg_state(dbg_state)
    );

    fc_layer_mp #(.Relu_En(0)) u_dut_nr (
        .clk(clk), .res_n(res_n), .en_l_b(en_l_b), .in_weights(in_weights),
        .in_start(in_start), .in_valid(in_valid), .in_ready(in_ready_nr),
        .in_data(in_data), .in_partial_sum(in_partial_sum), .out_ready(out_ready),
        .out_valid(out_valid_nr), .out_start(out_start_nr), .out_done(out_done_nr),
        .out_data(out_data_nr), .out_err(out_err_nr), .weights_loaded(wl_nr),
        .dbg_state(dbg_state_nr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_nr_q[$];
    int          tw [4][4];
    int          cur_bias [4];
    int          cur_d [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sext2(input logic [1:0] v);
        return v[1] ? int'(v) - 4 : int'(v);
    endfunction

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic push_expected();
        int          s;
        int          r_relu [4];
        int          r_raw [4];
        logic [7:0]  lo, hi;
        for (int j = 0; j < 4; j++) begin
            s = cur_bias[j];
            for (int k = 0; k < 4; k++) s += cur_d[k] * tw[k][j];
            r_raw[j]  = clamp8(s);
            r_relu[j] = clamp8((s < 0) ? 0 : s);
        end
        for (int c = 0; c < 2; c++) begin
            lo = 8'(r_relu[2*c]);  hi = 8'(r_relu[2*c+1]);
            exp_q.push_back({hi, lo});
            lo = 8'(r_raw[2*c]);   hi = 8'(r_raw[2*c+1]);
            exp_nr_q.push_back({hi, lo});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load_row(input int k, input logic [15:0] bits);
        for (int j = 0; j < 4; j++) tw[k][j] = sext2(bits[j*4 +: 2]);
        en_l_b     = 1'b1;
        in_weights = bits;
        @(negedge clk);
        check("load_in_ready", in_ready, 0);
        @(posedge clk); #1;
        en_l_b = 1'b0;
    endtask

    task automatic send_beat(input logic st, input int a, input int b);
        int n;
        in_valid = 1'b1;
        in_start = st;
        in_data  = {8'(b), 8'(a)};
        for (int j = 0; j < 4; j++) in_partial_sum[j*8 +: 8] = 8'(cur_bias[j]);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic collect(input int stall);
        logic [15:0] e0, e1;
        @(negedge clk);
        check("post_gap_valid", out_valid, 0);
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        check("latency_valid_nr", out_valid_nr, 1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_start", out_start, 1);
            check("stall_in_ready", in_ready, 0);
            if (exp_q.size() != 0) check("stall_data", out_data, exp_q[0]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            check("exp_q_nonempty", exp_q.size() != 0, 1);
            e0 = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            e1 = (exp_nr_q.size() != 0) ? exp_nr_q.pop_front() : 16'hxxxx;
            check("chunk_valid", out_valid, 1);
            check("chunk_start", out_start, c == 0);
            check("chunk_done", out_done, c == 1);
            check("chunk_data", out_data, e0);
            check("chunk_data_nr", out_data_nr, e1);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_vector(input int stall);
        push_expected();
        if (stall > 0) out_ready = 1'b0;
        send_beat(1'b1, cur_d[0], cur_d[1]);
        send_beat(1'b0, cur_d[2], cur_d[3]);
        collect(stall);
    endtask

    task automatic set_vec(input int b0, b1, b2, b3, d0, d1, d2, d3);
        cur_bias[0] = b0; cur_bias[1] = b1; cur_bias[2] = b2; cur_bias[3] = b3;
        cur_d[0] = d0; cur_d[1] = d1; cur_d[2] = d2; cur_d[3] = d3;
    endtask

    task automatic rand_vec();
        logic [7:0] rb;
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255)); cur_d[k] = int'($signed(rb));
            rb = 8'($urandom_range(0, 255)); cur_bias[k] = int'($signed(rb));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        res_n = 1'b0; en_l_b = 1'b0; in_weights = '0; in_start = 1'b0;
        in_valid = 1'b0; in_data = '0; in_partial_sum = '0; out_ready = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_start", out_start, 0);
        check("rst_out_done", out_done, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_weights_loaded", weights_loaded, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;

        // Partial weight load: three of four rows (+1 each, upper bits set).
        for (int k = 0; k < 3; k++) load_row(k, 16'hDDDD);
        @(negedge clk);
        check("partial_wl", weights_loaded, 0);
        check("partial_in_ready", in_ready, 0);
        check("partial_state", dbg_state, 0);
        @(posedge clk); #1;
        load_row(3, 16'hDDDD);
        @(negedge clk);
        check("full_wl", weights_loaded, 1);
        check("full_in_ready", in_ready, 1);
        check("full_state", dbg_state, 1);
        @(posedge clk); #1;

        // [1,2],[3,4] with +1 weights, zero bias -> 10 everywhere.
        set_vec(0, 0, 0, 0, 1, 2, 3, 4);
        run_vector(0);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Positive saturation: 127 + 4*127 = 635 -> 127.
        set_vec(127, 127, 127, 127, 127, 127, 127, 127);
        run_vector(0);

        // Reload with -2 from IDLE: weights_loaded must fall after the first row.
        load_row(0, 16'h6666);
        @(negedge clk);
        check("reload_wl_fell", weights_loaded, 0);
        check("reload_state", dbg_state, 0);
        @(posedge clk); #1;
        for (int k = 1; k < 4; k++) load_row(k, 16'h6666);

        // -1016: ReLU -> 0, no ReLU -> saturates to -128.
        set_vec(0, 0, 0, 0, 127, 127, 127, 127);
        run_vector(0);

        // Backpressure: 5 stalled cycles in OUT.
        set_vec(20, -20, 50, -50, -5, 10, 3, -7);
        run_vector(5);
        @(negedge clk);
        check("after_stall_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Random weights for the remaining vectors.
        for (int k = 0; k < 4; k++) load_row(k, 16'($urandom_range(0, 65535)));

        // Framing: start, then a second start mid-vector -> restart + error pulse.
        set_vec(1, 2, 3, 4, 99, -99, 0, 0);
        send_beat(1'b1, cur_d[0], cur_d[1]);
        @(negedge clk);
        check("first_start_err", out_err, 0);
        @(posedge clk); #1;
        set_vec(1, 2, 3, 4, 10, 20, 30, 40);
        push_expected();
        send_beat(1'b1, cur_d[0], cur_d[1]);
        @(negedge clk);
        check("restart_err", out_err, 1);
        check("restart_err_nr", out_err_nr, 1);
        @(negedge clk);
        check("restart_err_cleared", out_err, 0);
        check("restart_state", dbg_state, 2);
        @(posedge clk); #1;
        send_beat(1'b0, cur_d[2], cur_d[3]);
        collect(0);

        // Beat without in_start in IDLE is dropped with an error pulse.
        send_beat(1'b0, 9, 9);
        @(negedge clk);
        check("drop_err", out_err, 1);
        check("drop_out_valid", out_valid, 0);
        @(negedge clk);
        check("drop_err_cleared", out_err, 0);
        check("drop_state", dbg_state, 1);
        check("drop_out_valid2", out_valid, 0);
        @(posedge clk); #1;

        // Random vectors with random backpressure.
        for (int v = 0; v < 4; v++) begin
            rand_vec();
            run_vector($urandom_range(0, 3));
        end

        // Reset in the middle of OUT.
        set_vec(1, 1, 1, 1, 5, 5, 5, 5);
        send_beat(1'b1, 5, 5);
        send_beat(1'b0, 5, 5);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_valid", out_valid, 1);
        #1 res_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_start", out_start, 0);
        check("mid_rst_out_done", out_done, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_err", out_err, 0);
        check("mid_rst_wl", weights_loaded, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_data_nr", out_data_nr, 0);
        @(posedge clk);
        @(posedge clk); #1;
        res_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", dbg_state, 0);
        check("post_rst_wl", weights_loaded, 0);
        check("post_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // Zero weights (only upper container bits set): result is the bias.
        for (int k = 0; k < 4; k++) load_row(k, 16'hCCCC);
        set_vec(5, -3, 100, -100, 77, -12, 45, 120);
        run_vector(0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
